// File: rtl/uart_tx_framer.sv
`default_nettype none
// uart_tx_framer: UART transmitter with built-in baud divider; frame format comes from usr_options,
// which is latched together with tx_data when a byte is accepted.
module uart_tx_framer #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] usr_options,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       cts,
  output logic       serial_out,
  output logic       busy,
  output logic       done
);

  localparam int DIV_W = $clog2(CLK_FREQ / 9600);

  localparam logic [DIV_W-1:0] c_DIV_9600   = DIV_W'(CLK_FREQ / 9600 - 1);
  localparam logic [DIV_W-1:0] c_DIV_19200  = DIV_W'(CLK_FREQ / 19200 - 1);
  localparam logic [DIV_W-1:0] c_DIV_57600  = DIV_W'(CLK_FREQ / 57600 - 1);
  localparam logic [DIV_W-1:0] c_DIV_115200 = DIV_W'(CLK_FREQ / 115200 - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CTS = 3'd1,
    S_START    = 3'd2,
    S_DATA     = 3'd3,
    S_PARITY   = 3'd4,
    S_STOP     = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [DIV_W-1:0] r_div_max, w_div_sel;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_data;
  logic [4:0]       r_cfg;
  logic             r_line, w_line_nxt;
  logic             r_done, w_done_nxt;
  logic             w_load;
  logic             w_bit_end;
  logic             w_parity;
  logic [2:0]       w_last_bit;
  logic [2:0]       w_bit_inc;

  always_comb begin
    case (usr_options[7:6])
      2'd0:    w_div_sel = c_DIV_9600;
      2'd1:    w_div_sel = c_DIV_19200;
      2'd2:    w_div_sel = c_DIV_57600;
      default: w_div_sel = c_DIV_115200;
    endcase
  end

  // r_data holds only the n live bits, so a plain reduction gives the data parity.
  assign w_bit_end  = (r_div == r_div_max);
  assign w_last_bit = 3'd7 - {1'b0, r_cfg[3:2]};
  assign w_bit_inc  = r_bit + 3'd1;
  assign w_parity   = (^r_data) ^ r_cfg[1];

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_line_nxt  = r_line;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_line_nxt = 1'b1;
        w_div_nxt  = '0;
        w_bit_nxt  = '0;
        if (tx_valid) begin
          w_load = 1'b1;
          if (usr_options[5] && !cts) begin
            w_state_nxt = S_WAIT_CTS;
          end else begin
            w_state_nxt = S_START;
            w_line_nxt  = 1'b0;
          end
        end
      end
      S_WAIT_CTS: begin
        w_line_nxt = 1'b1;
        if (cts) begin
          w_state_nxt = S_START;
          w_line_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
          w_line_nxt  = r_data[0];
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_div_nxt = '0;
          if (r_bit == w_last_bit) begin
            w_bit_nxt = '0;
            if (r_cfg[0]) begin
              w_state_nxt = S_PARITY;
              w_line_nxt  = w_parity;
            end else begin
              w_state_nxt = S_STOP;
              w_line_nxt  = 1'b1;
            end
          end else begin
            w_bit_nxt  = w_bit_inc;
            w_line_nxt = r_data[w_bit_inc];
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_STOP;
          w_line_nxt  = 1'b1;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_STOP: begin
        w_line_nxt = 1'b1;
        if (w_bit_end) begin
          w_div_nxt = '0;
          if (r_cfg[4] && (r_bit == 3'd0)) begin
            w_bit_nxt = 3'd1;
          end else begin
            w_bit_nxt   = '0;
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_line_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_line  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_line  <= w_line_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_data    <= '0;
      r_cfg     <= '0;
      r_div_max <= '0;
    end else if (w_load) begin
      r_data    <= tx_data & (8'hFF >> usr_options[3:2]);
      r_cfg     <= usr_options[4:0];
      r_div_max <= w_div_sel;
    end
  end

  assign tx_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign serial_out = r_line;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// tb_uart_tx_framer: frames checked cycle by cycle against a bit-list model built from the frame rules.
module tb_uart_tx_framer;

  localparam int CLK_FREQ = 1_152_000;

  logic       sys_clk;
  logic       reset;
  logic [7:0] usr_options;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       cts;
  logic       serial_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  uart_tx_framer #(.CLK_FREQ(CLK_FREQ)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .usr_options (usr_options),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .cts         (cts),
    .serial_out  (serial_out),
    .busy        (busy),
    .done        (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected line levels, one entry per bit, plus the bit period for the chosen baud.
  task automatic build_model(input logic [7:0] opt, input logic [7:0] data, output int div);
    int   n;
    logic x;
    case (opt[7:6])
      2'd0:    div = CLK_FREQ / 9600;
      2'd1:    div = CLK_FREQ / 19200;
      2'd2:    div = CLK_FREQ / 57600;
      default: div = CLK_FREQ / 115200;
    endcase
    n = 8 - int'(opt[3:2]);
    x = 1'b0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(data[i]);
      x = x ^ data[i];
    end
    if (opt[0]) exp_q.push_back(opt[1] ? ~x : x);
    exp_q.push_back(1'b1);
    if (opt[4]) exp_q.push_back(1'b1);
  endtask

  task automatic start_frame(input logic [7:0] opt, input logic [7:0] data, input int cts_wait);
    @(posedge sys_clk); #1;
    usr_options = opt;
    tx_data     = data;
    tx_valid    = 1'b1;
    if (cts_wait > 0) cts = 1'b0;
    else              cts = opt[5] ? 1'b1 : 1'($urandom);
    @(negedge sys_clk);
    check("ready_before_accept", 32'(tx_ready), 32'd1);
    @(posedge sys_clk); #1;
    tx_valid    = 1'b0;
    usr_options = 8'($urandom);
    tx_data     = 8'($urandom);
    if (cts_wait == 0) cts = 1'($urandom);
    for (int w = 0; w < cts_wait; w++) begin
      @(negedge sys_clk);
      check("cts_wait_line", 32'(serial_out), 32'd1);
      check("cts_wait_busy", 32'(busy), 32'd1);
      check("cts_wait_ready", 32'(tx_ready), 32'd0);
    end
    if (cts_wait > 0) cts = 1'b1;
  endtask

  task automatic check_frame(input logic [7:0] opt, input logic [7:0] data, input bit chain);
    int div;
    int total;
    build_model(opt, data, div);
    total = exp_q.size() * div;
    for (int k = 0; k < total; k++) begin
      @(negedge sys_clk);
      check("line", 32'(serial_out), 32'(exp_q[k / div]));
      if (k == 0) begin
        check("busy_in_frame", 32'(busy), 32'd1);
        check("ready_in_frame", 32'(tx_ready), 32'd0);
      end
      if (k == total - 1) check("done_early", 32'(done), 32'd0);
    end
    @(negedge sys_clk);
    check("done_pulse", 32'(done), 32'd1);
    check("ready_at_done", 32'(tx_ready), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("line_at_done", 32'(serial_out), 32'd1);
    if (!chain) begin
      @(negedge sys_clk);
      check("done_width", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] opt;
    logic [7:0] dat;
    int         div;
    int         wt;

    reset       = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    usr_options = 8'h00;
    cts         = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_line", 32'(serial_out), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge sys_clk);

    start_frame(8'hC0, 8'h55, 0);
    check_frame(8'hC0, 8'h55, 1'b0);

    start_frame(8'hD7, 8'h41, 0);
    check_frame(8'hD7, 8'h41, 1'b0);

    start_frame(8'hE0, 8'h9B, 50);
    check_frame(8'hE0, 8'h9B, 1'b0);

    start_frame(8'hCD, 8'hFF, 0);
    check_frame(8'hCD, 8'hFF, 1'b0);

    // Abort during the fourth data bit.
    start_frame(8'hC0, 8'hA6, 0);
    build_model(8'hC0, 8'hA6, div);
    for (int k = 0; k < 44; k++) begin
      @(negedge sys_clk);
      check("pre_abort_line", 32'(serial_out), 32'(exp_q[k / div]));
    end
    #2 reset = 1'b0;
    #1;
    check("abort_line", 32'(serial_out), 32'd1);
    check("abort_ready", 32'(tx_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge sys_clk);
      check("post_abort_idle", 32'(serial_out), 32'd1);
      check("post_abort_no_done", 32'(done), 32'd0);
    end
    start_frame(8'hC0, 8'h3A, 0);
    check_frame(8'hC0, 8'h3A, 1'b0);

    // Back-to-back at 9600: options change mid-frame, second frame picks them up at its accept.
    start_frame(8'h00, 8'hA5, 0);
    usr_options = 8'h1F;
    tx_data     = 8'h3C;
    tx_valid    = 1'b1;
    check_frame(8'h00, 8'hA5, 1'b1);
    @(posedge sys_clk); #1;
    tx_valid    = 1'b0;
    usr_options = 8'($urandom);
    check_frame(8'h1F, 8'h3C, 1'b0);

    repeat (25) begin
      opt    = 8'($urandom);
      opt[7] = 1'b1;
      dat    = 8'($urandom);
      wt     = opt[5] ? $urandom_range(0, 8) : 0;
      start_frame(opt, dat, wt);
      check_frame(opt, dat, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
